wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs, plus the architectural register file.
- Selects the writeback value, decodes the destination register from the instruction word, and commits to a 32x32 register file on the clock edge.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Exports the current writeback target to the forwarding unit.

Parameters:
- DATA_W, 32, register and data width
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- inst_i  in  32  instruction word from MEM/WB
- WB_signal_i  in  2  [1]=RegWrite, [0]=MemtoReg
- MEMdata_i  in  32  load data from MEM/WB
- ALUResult_i  in  32  ALU result from MEM/WB
- rs_addr_i  in  5  ID read port A address
- rt_addr_i  in  5  ID read port B address
- rs_data_o  out  32  read port A data
- rt_data_o  out  32  read port B data
- wb_we_o  out  1  effective write enable, to forwarding unit
- wb_rd_o  out  5  writeback destination, to forwarding unit
- wb_data_o  out  32  writeback value, to forwarding unit

Behaviour:
- Reset:
  - Asynchronous: rst_i low clears all NREG registers to 0 immediately, independent of clk_i.
  - Outputs are combinational, so during reset rs_data_o = rt_data_o = 0 unless bypassed. Bypass is suppressed while rst_i is low.
- Writeback mux: wb_data_o = WB_signal_i[0] ? MEMdata_i : ALUResult_i.
- Destination decode, from opcode inst_i[31:26]:
  - 6'b000000 (R-type): inst_i[15:11] (rd).
  - Any other opcode: inst_i[20:16] (rt).
- Write enable: wb_we_o = WB_signal_i[1] && (wb_rd_o != 0) && rst_i.
- Commit: on posedge clk_i with wb_we_o=1, reg[wb_rd_o] <= wb_data_o. Write latency is 1 cycle; the value is visible in the array from the next cycle.
- Register 0:
  - Never written; always reads 0, including when a write targets register 0.
  - A write to register 0 also produces wb_we_o=0.
- Read ports are combinational, 0-cycle latency:
  - If addr==0, the port reads 0.
  - Else if wb_we_o && addr==wb_rd_o, the port returns wb_data_o (write-before-read bypass).
  - Else the port returns reg[addr].
- Both read ports may address the same register. Both may hit the bypass simultaneously; each resolves independently.
- No stall or flush input: a bubble arrives as WB_signal_i=2'b00, which writes nothing.
- Reset asserted mid-write: the register is not written on that edge. After rst_i deasserts, the array is all zero.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt_o (32 bits).
  - The counter increments by 1 on each posedge where WB_signal_i != 2'b00; writes to register 0 are counted.
  - Wraps from 0xFFFFFFFF to 0.
  - Asynchronously cleared to 0 by rst_i low.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - OP_RTYPE = 6'b000000
  - WB_REGWRITE_BIT = 1, WB_MEMTOREG_BIT = 0
  - REG_ADDR_W = 5
  - DATA_W default
- One natural sub-module, regfile_2r1w: the storage array with async clear, one write port, two raw read ports and the register-0 rule.
- wb_regfile wraps regfile_2r1w with the writeback mux, destination decode, bypass logic and the optional counter.

Test Plan:
- Reset: rst_i low for 2 cycles, then high; read every address 0..31 on both ports -> all read 0.
- R-type commit:
  - Drive inst_i=0x012A4020 (add $8,$9,$10), WB_signal_i=2'b10, ALUResult_i=0x0000BEEF.
  - Same cycle, rs_addr_i=8 -> rs_data_o=0x0000BEEF via bypass.
  - Next cycle, with WB_signal_i=0 -> rs_data_o still 0x0000BEEF.
- Load commit:
  - Drive inst_i=0x8C0B0004 (lw $11), WB_signal_i=2'b11, MEMdata_i=0x12345678, ALUResult_i=0xDEAD0000.
  - Required: wb_rd_o=11, wb_data_o=0x12345678; reg 11 reads 0x12345678 after the edge.
- Register 0:
  - Drive an R-type with rd=0, WB_signal_i=2'b10, ALUResult_i=0xFFFFFFFF.
  - Required: wb_we_o=0; rs_addr_i=0 -> 0, both same cycle and next cycle.
- Dual-port same address:
  - Preload reg 5 = 0x11; then drive a write of 0x22 to reg 5 with rs_addr_i=rt_addr_i=5.
  - Required: both ports read 0x22 in the write cycle and in the next cycle.
- Async reset mid-operation, plus counter:
  - Issue 3 writes, with WB_retire_cnt_EN defined: retire_cnt_o=3.
  - Pulse rst_i low between clock edges -> retire_cnt_o=0 and all registers read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback control bit positions, opcode constants,
// register-file geometry and the writeback destination decode helper.
// Ports: none (package). Imported by regfile_2r1w and wb_regfile.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  // Bit positions inside the 2-bit WB control field carried by MEM/WB.
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  // R-type instructions write rd; every other writing instruction writes rt.
  function automatic logic [REG_ADDR_W-1:0] wb_dest(input logic [5:0] opcode,
                                                    input logic [REG_ADDR_W-1:0] rt,
                                                    input logic [REG_ADDR_W-1:0] rd);
    return (opcode == OP_RTYPE) ? rd : rt;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: NREG x DATA_W, one write port, two raw
// combinational read ports, async active-low clear, register 0 hard-wired to 0.
// Ports: clk, rst_n, we/waddr/wdata (commit on rising edge), raddr_a/b -> rdata_a/b.
// Latency: write visible in the array the cycle after the edge; reads 0-cycle.
// Backpressure: none, a write is always accepted.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW   = DATA_W,
  parameter int NR   = NREG,
  parameter int AW   = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Register 0 is never written, but force the read to zero as well so the
  // rule does not depend on the storage cell staying at its reset value.
  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file: selects the writeback value, decodes the
// destination, commits on the rising edge and serves two bypassed read ports.
// Ports: clk_i, rst_i (async, active-low); MEM/WB inputs inst_i, WB_signal_i,
//   MEMdata_i, ALUResult_i; ID read ports rs/rt_addr_i -> rs/rt_data_o;
//   forwarding outputs wb_we_o, wb_rd_o, wb_data_o.
// Latency: reads 0-cycle with same-cycle write bypass; writes commit in 1 cycle.
// Backpressure: none; a bubble is WB_signal_i = 2'b00.
// Optional: define WB_RETIRE_CNT_EN to add retire_cnt_o, a wrapping count of
//   cycles with non-zero WB_signal_i (register-0 writes included).
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREG   = cpu_pkg::NREG
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           inst_i,
  input  logic [1:0]            WB_signal_i,
  input  logic [DATA_W-1:0]     MEMdata_i,
  input  logic [DATA_W-1:0]     ALUResult_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic                  wb_we_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]     wb_data_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_cnt_o
`endif
);

  logic [DATA_W-1:0] raw_rs;
  logic [DATA_W-1:0] raw_rt;

  // Source-register and shamt/funct fields are not needed at writeback.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_i[25:21], inst_i[10:0]};

  assign wb_data_o = WB_signal_i[WB_MEMTOREG_BIT] ? MEMdata_i : ALUResult_i;
  assign wb_rd_o   = wb_dest(inst_i[31:26], inst_i[20:16], inst_i[15:11]);

  // Gating with rst_i both blocks a commit on an edge during reset and
  // suppresses the read bypass while the array is being cleared.
  assign wb_we_o = WB_signal_i[WB_REGWRITE_BIT] && (wb_rd_o != '0) && rst_i;

  regfile_2r1w #(
    .DW (DATA_W),
    .NR (NREG),
    .AW (REG_ADDR_W)
  ) u_rf (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .we      (wb_we_o),
    .waddr   (wb_rd_o),
    .wdata   (wb_data_o),
    .raddr_a (rs_addr_i),
    .raddr_b (rt_addr_i),
    .rdata_a (raw_rs),
    .rdata_b (raw_rt)
  );

  // Write-before-read: ID sees the value being committed this cycle.
  assign rs_data_o = (rs_addr_i == '0)                     ? '0        :
                     (wb_we_o && (rs_addr_i == wb_rd_o))   ? wb_data_o : raw_rs;
  assign rt_data_o = (rt_addr_i == '0)                     ? '0        :
                     (wb_we_o && (rt_addr_i == wb_rd_o))   ? wb_data_o : raw_rt;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retire_cnt_o <= '0;
    end else if (WB_signal_i != 2'b00) begin
      retire_cnt_o <= retire_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i;
  logic [1:0]  WB_signal_i;
  logic [31:0] MEMdata_i;
  logic [31:0] ALUResult_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  wb_regfile dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inst_i      (inst_i),
    .WB_signal_i (WB_signal_i),
    .MEMdata_i   (MEMdata_i),
    .ALUResult_i (ALUResult_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .wb_we_o     (wb_we_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o(retire_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mreg [32];
  logic [31:0] mcnt;

  function automatic logic [4:0] m_dest(input logic [31:0] inst);
    return (inst[31:26] == 6'd0) ? inst[15:11] : inst[20:16];
  endfunction

  function automatic logic [31:0] m_value();
    return WB_signal_i[0] ? MEMdata_i : ALUResult_i;
  endfunction

  function automatic logic m_we();
    return (rst_i === 1'b1) && WB_signal_i[1] && (m_dest(inst_i) != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == m_dest(inst_i)) return m_value();
    return mreg[a];
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) mreg[i] <= 32'd0;
      mcnt <= 32'd0;
    end else begin
      if (m_we()) mreg[m_dest(inst_i)] <= m_value();
      if (WB_signal_i != 2'b00) mcnt <= mcnt + 32'd1;
    end
  end

  // Every cycle: outputs against the model, away from the active edge.
  always @(negedge clk_i) begin
    check("cyc_wb_data", wb_data_o, m_value());
    check("cyc_wb_rd", {27'd0, wb_rd_o}, {27'd0, m_dest(inst_i)});
    check("cyc_wb_we", {31'd0, wb_we_o}, {31'd0, m_we()});
    check("cyc_rs_data", rs_data_o, m_read(rs_addr_i));
    check("cyc_rt_data", rt_data_o, m_read(rt_addr_i));
`ifdef WB_RETIRE_CNT_EN
    check("cyc_retire_cnt", retire_cnt_o, mcnt);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input logic [31:0] inst, input logic [1:0] wb,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt);
    @(posedge clk_i);
    #1;
    inst_i      = inst;
    WB_signal_i = wb;
    MEMdata_i   = mem;
    ALUResult_i = alu;
    rs_addr_i   = rs;
    rt_addr_i   = rt;
  endtask

  task automatic bubble(input logic [4:0] rs, input logic [4:0] rt);
    apply(32'h0, 2'b00, 32'h0, 32'h0, rs, rt);
  endtask

  initial begin
    rst_i       = 1'b0;
    inst_i      = 32'h0;
    WB_signal_i = 2'b00;
    MEMdata_i   = 32'h0;
    ALUResult_i = 32'h0;
    rs_addr_i   = 5'd7;
    rt_addr_i   = 5'd9;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_rs_data", rs_data_o, 32'h0);
    check("reset_wb_we", {31'd0, wb_we_o}, 32'd0);
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bubble(i[4:0], 5'(31 - i));
      #1;
      check("reset_sweep_rs", rs_data_o, 32'h0);
      check("reset_sweep_rt", rt_data_o, 32'h0);
    end

    // R-type add $8,$9,$10: bypass in the write cycle, array afterwards.
    apply(32'h012A4020, 2'b10, 32'h0, 32'h0000BEEF, 5'd8, 5'd10);
    #1;
    check("rtype_wb_rd", {27'd0, wb_rd_o}, 32'd8);
    check("rtype_wb_we", {31'd0, wb_we_o}, 32'd1);
    check("rtype_bypass_rs", rs_data_o, 32'h0000BEEF);
    check("rtype_other_rt", rt_data_o, 32'h0);
    bubble(5'd8, 5'd0);
    #1;
    check("rtype_commit_rs", rs_data_o, 32'h0000BEEF);

    // lw $11: rt destination, MEMdata selected.
    apply(32'h8C0B0004, 2'b11, 32'h12345678, 32'hDEAD0000, 5'd11, 5'd8);
    #1;
    check("load_wb_rd", {27'd0, wb_rd_o}, 32'd11);
    check("load_wb_data", wb_data_o, 32'h12345678);
    check("load_bypass_rs", rs_data_o, 32'h12345678);
    bubble(5'd11, 5'd8);
    #1;
    check("load_commit_rs", rs_data_o, 32'h12345678);
    check("load_keep_rt", rt_data_o, 32'h0000BEEF);

    // addi $12: non-R-type with MemtoReg=0 picks the ALU result.
    apply(32'h200C0007, 2'b10, 32'h55555555, 32'h0000A5A5, 5'd12, 5'd12);
    #1;
    check("addi_wb_data", wb_data_o, 32'h0000A5A5);
    check("addi_wb_rd", {27'd0, wb_rd_o}, 32'd12);

    // R-type with rd=0: no write enable, register 0 stays zero.
    apply(32'h01290020, 2'b10, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("r0_wb_we", {31'd0, wb_we_o}, 32'd0);
    check("r0_rs_same", rs_data_o, 32'h0);
    bubble(5'd0, 5'd0);
    #1;
    check("r0_rs_next", rs_data_o, 32'h0);

    // MemtoReg-only bubble: counted but writes nothing.
    apply(32'h8C0D0000, 2'b01, 32'h77777777, 32'h0, 5'd13, 5'd0);
    #1;
    check("memonly_wb_we", {31'd0, wb_we_o}, 32'd0);
    check("memonly_rs", rs_data_o, 32'h0);

    // Dual-port same address: preload 0x11 into $5, then overwrite with 0x22.
    apply(32'h00002820, 2'b10, 32'h0, 32'h00000011, 5'd5, 5'd5);
    apply(32'h00002820, 2'b10, 32'h0, 32'h00000022, 5'd5, 5'd5);
    #1;
    check("dual_bypass_rs", rs_data_o, 32'h00000022);
    check("dual_bypass_rt", rt_data_o, 32'h00000022);
    bubble(5'd5, 5'd5);
    #1;
    check("dual_commit_rs", rs_data_o, 32'h00000022);
    check("dual_commit_rt", rt_data_o, 32'h00000022);

    // Async reset pulse between edges clears everything immediately.
    bubble(5'd5, 5'd8);
    #2;
    rst_i = 1'b0;
    #1;
    check("pulse_rs", rs_data_o, 32'h0);
    check("pulse_rt", rt_data_o, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    check("pulse_cnt", retire_cnt_o, 32'h0);
`endif
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bubble(i[4:0], 5'(31 - i));
      #1;
      check("post_pulse_rs", rs_data_o, 32'h0);
      check("post_pulse_rt", rt_data_o, 32'h0);
    end

    // Three writes from a clean state.
    apply(32'h20010000, 2'b10, 32'h0, 32'h00000101, 5'd0, 5'd0);
    apply(32'h20020000, 2'b10, 32'h0, 32'h00000102, 5'd0, 5'd0);
    apply(32'h20030000, 2'b10, 32'h0, 32'h00000103, 5'd0, 5'd0);
    bubble(5'd1, 5'd3);
    #1;
    check("three_rs", rs_data_o, 32'h00000101);
    check("three_rt", rt_data_o, 32'h00000103);
`ifdef WB_RETIRE_CNT_EN
    check("three_cnt", retire_cnt_o, 32'd3);
`endif

    // Reset asserted during a write cycle and held over the edge: no commit.
    apply(32'h20040000, 2'b10, 32'h0, 32'h00000444, 5'd4, 5'd2);
    #1;
    check("midwr_bypass", rs_data_o, 32'h00000444);
    #1;
    rst_i = 1'b0;
    #1;
    check("midwr_rs", rs_data_o, 32'h0);
    check("midwr_rt", rt_data_o, 32'h0);
    check("midwr_we", {31'd0, wb_we_o}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("midwr_cnt", retire_cnt_o, 32'h0);
`endif
    @(posedge clk_i);
    #1;
    inst_i      = 32'h0;
    WB_signal_i = 2'b00;
    rst_i       = 1'b1;
    bubble(5'd4, 5'd2);
    #1;
    check("after_rs4", rs_data_o, 32'h0);
    check("after_rt2", rt_data_o, 32'h0);

    repeat (2) @(posedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
